// File: rtl/cos_lut_arb.sv
// cos_lut_arb: round-robin arbiter sharing one synchronous-read cos LUT port among NUM_REQ
// requesters, with a fixed 3-cycle grant-to-response pipeline.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en_i         arbitration enable (low blocks new grants; in-flight reads still drain)
//   req_i        per-requester read request, held until granted
//   req_addr_i   packed request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt_o        combinational one-hot (or zero) grant
//   lut_addr_o   registered LUT address
//   lut_data_i   LUT read data (1-cycle read latency from lut_addr_o)
//   rsp_valid_o  registered response strobe
//   rsp_id_o     requester index owning rsp_data_o
//   rsp_data_o   registered LUT data
module cos_lut_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 18,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [ADDR_WIDTH-1:0]         lut_addr_o,
    input  logic [WIDTH-1:0]              lut_data_i,
    output logic                          rsp_valid_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic [WIDTH-1:0]              rsp_data_o
);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] lut_addr_q;
    logic                  s1_valid_q, s2_valid_q, rsp_valid_q;
    logic [ID_WIDTH-1:0]   s1_id_q, s2_id_q, rsp_id_q;
    logic [WIDTH-1:0]      rsp_data_q;

    logic                  grant_any;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ID_WIDTH:0]     cand;

    // Round-robin search from ptr_q; one extra bit in cand holds ptr+i before the wrap.
    always_comb begin
        gnt_o     = '0;
        gnt_id    = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_any && en_i && !rst && req_i[cand[ID_WIDTH-1:0]]) begin
                grant_any = 1'b1;
                gnt_id    = cand[ID_WIDTH-1:0];
                gnt_o[cand[ID_WIDTH-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Stage 1: address to LUT. Stage 2: LUT sampling lut_addr. Then capture of lut_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            lut_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= grant_any;
            if (grant_any) begin
                lut_addr_q <= sel_addr;
                s1_id_q    <= gnt_id;
            end
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
            rsp_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                rsp_id_q   <= s2_id_q;
                rsp_data_q <= lut_data_i;
            end
        end
    end

    assign lut_addr_o  = lut_addr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_cos_lut_arb.sv
// Self-checking bench for cos_lut_arb: table of {en, req, expected gnt} vectors plus
// hand-written reset sequences; a scoreboard queue predicts every response 3 cycles out.
module tb_cos_lut_arb;

    localparam int NR  = 4;
    localparam int W   = 18;
    localparam int AW  = 12;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic [NR-1:0]     req_i;
    logic [NR*AW-1:0]  req_addr_i;
    logic [NR-1:0]     gnt_o;
    logic [AW-1:0]     lut_addr_o;
    logic [W-1:0]      lut_data;
    logic              rsp_valid_o;
    logic [IDW-1:0]    rsp_id_o;
    logic [W-1:0]      rsp_data_o;

    logic [AW-1:0]     addr [NR];

    cos_lut_arb #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .ADDR_WIDTH(AW),
        .ID_WIDTH  (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .req_i      (req_i),
        .req_addr_i (req_addr_i),
        .gnt_o      (gnt_o),
        .lut_addr_o (lut_addr_o),
        .lut_data_i (lut_data),
        .rsp_valid_o(rsp_valid_o),
        .rsp_id_o   (rsp_id_o),
        .rsp_data_o (rsp_data_o)
    );

    always #5 clk = ~clk;

    assign req_addr_i = {addr[3], addr[2], addr[1], addr[0]};

    function automatic logic [W-1:0] lut_f(input logic [AW-1:0] a);
        logic [W-1:0] p;
        p = W'(a) * W'(97);
        return p ^ 18'h2A5A5;
    endfunction

    // Behavioural LUT with one-cycle synchronous read.
    always @(posedge clk) lut_data <= lut_f(lut_addr_o);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } sb_t;
    sb_t sb [$];

    logic [IDW-1:0] last_id   = '0;
    logic [W-1:0]   last_data = '0;
    logic [AW-1:0]  exp_la    = '0;

    // Response monitor: every cycle is either a predicted response or a held idle output.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                sb_t e;
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
                chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
                chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
                last_id   = IDW'(e.id);
                last_data = e.data;
            end else begin
                chk("rsp_idle_valid", 32'(rsp_valid_o), 32'd0);
                chk("rsp_hold_id", 32'(rsp_id_o), 32'(last_id));
                chk("rsp_hold_data", 32'(rsp_data_o), 32'(last_data));
            end
        end
    end

    function automatic int idx_of(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) if (g[i]) return i;
        return 0;
    endfunction

    // One arbitration cycle: drive after the edge, check grant mid-cycle, predict response.
    task automatic step(input bit e, input logic [NR-1:0] r, input logic [NR-1:0] g,
                        input string nm);
        int id;
        @(posedge clk);
        #1;
        chk({nm, "/lut_addr"}, 32'(lut_addr_o), 32'(exp_la));
        en_i  = e;
        req_i = r;
        @(negedge clk);
        chk({nm, "/gnt"}, 32'(gnt_o), 32'(g));
        if (g != '0) begin
            id = idx_of(g);
            sb.push_back('{id, lut_f(addr[id]), cyc + 3});
            exp_la = addr[id];
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "/gnt"}, 32'(gnt_o), 32'd0);
        chk({nm, "/lut_addr"}, 32'(lut_addr_o), 32'd0);
        chk({nm, "/rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({nm, "/rsp_id"}, 32'(rsp_id_o), 32'd0);
        chk({nm, "/rsp_data"}, 32'(rsp_data_o), 32'd0);
    endtask

    typedef struct {
        bit            en;
        logic [NR-1:0] req;
        logic [NR-1:0] gnt;
        string         nm;
    } vec_t;
    vec_t vecs [$];

    function automatic void add(input bit e, input logic [3:0] r, input logic [3:0] g,
                                input string nm, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{e, r, g, nm});
    endfunction

    initial begin
        rst   = 1'b1;
        en_i  = 1'b1;
        req_i = 4'b1111;
        for (int i = 0; i < NR; i++) addr[i] = '0;

        // Build vectors; comments give the round-robin pointer before each group.
        // ptr=1 after the single read
        add(1, 4'b1111, 4'b0010, "rr_a", 1);
        add(1, 4'b1111, 4'b0100, "rr_b", 1);
        add(1, 4'b1111, 4'b1000, "rr_c", 1);
        add(1, 4'b1111, 4'b0001, "rr_d", 1);
        add(1, 4'b1111, 4'b0010, "rr_e", 1);
        add(1, 4'b1111, 4'b0100, "rr_f", 1);
        add(1, 4'b1111, 4'b1000, "rr_g", 1);
        add(1, 4'b1111, 4'b0001, "rr_h", 1);
        // ptr=1
        add(1, 4'b0100, 4'b0100, "wrap_set2", 1);
        add(1, 4'b1001, 4'b1000, "wrap_1001_a", 1);
        add(1, 4'b1001, 4'b0001, "wrap_1001_b", 1);
        add(1, 4'b0100, 4'b0100, "wrap_set2b", 1);
        add(1, 4'b0101, 4'b0001, "wrap_0101_a", 1);
        add(1, 4'b0101, 4'b0100, "wrap_0101_b", 1);
        // ptr=3
        add(1, 4'b0000, 4'b0000, "idle", 10);
        add(1, 4'b1111, 4'b1000, "drain_g0", 1);
        add(1, 4'b1111, 4'b0001, "drain_g1", 1);
        add(1, 4'b1111, 4'b0010, "drain_g2", 1);
        add(0, 4'b1111, 4'b0000, "drain_off", 5);
        add(1, 4'b1111, 4'b0100, "drain_reen", 1);
        // ptr=3
        add(0, 4'b0010, 4'b0000, "drop_noen", 1);
        add(1, 4'b0000, 4'b0000, "drop_idle", 4);

        // Reset holds outputs at zero even with requests asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("in_reset");
        req_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read at address 0.
        step(1, 4'b0001, 4'b0001, "single");
        for (int i = 0; i < 5; i++) step(1, 4'b0000, 4'b0000, "single_idle");

        addr[0] = 12'h010;
        addr[1] = 12'h020;
        addr[2] = 12'h030;
        addr[3] = 12'h040;

        foreach (vecs[i]) step(vecs[i].en, vecs[i].req, vecs[i].gnt, vecs[i].nm);

        // Reset mid-flight: two grants, then reset; nothing of them may come out.
        step(1, 4'b1111, 4'b1000, "mid_g0");
        step(1, 4'b1111, 4'b0001, "mid_g1");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        last_id   = '0;
        last_data = '0;
        exp_la    = '0;
        @(negedge clk);
        chk("mid_rst/gnt_held", 32'(gnt_o), 32'd0);
        req_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 4'b1111, 4'b0001, "post_rst_first");
        step(1, 4'b1111, 4'b0010, "post_rst_second");
        for (int i = 0; i < 6; i++) step(1, 4'b0000, 4'b0000, "post_rst_idle");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
